// File: rtl/enigma_qos_arb_if.sv
// Bus bundle for enigma_qos_arb: two request ports (A, B), the merged
// output port C, the core's conflict/release feedback, and status and
// debug observation signals.
//
// Handshake: a beat moves on a port in any cycle where both valid and
// ready are high at the rising clock edge. A request may drop or change
// while ready is low; ready_a/ready_b are combinational and never high
// for a port that is not presenting an eligible request. On port C,
// payload/id/qos are held stable for as long as valid_c is high and
// ready_c is low.
interface enigma_qos_arb_if;
    logic [127:0] payload_a;
    logic [4:0]   id_a;
    logic [1:0]   qos_a;
    logic         valid_a;
    logic         ready_a;

    logic [127:0] payload_b;
    logic [4:0]   id_b;
    logic [1:0]   qos_b;
    logic         valid_b;
    logic         ready_b;

    logic [127:0] payload_c;
    logic [5:0]   id_c;
    logic [1:0]   qos_c;
    logic         valid_c;
    logic         ready_c;

    logic         conflict_c;
    logic         release_c;
    logic [5:0]   releaseid_c;

    logic [6:0]   out_cnt;
    logic         err_release;

    // Arbitration state made visible for observation.
    logic [7:0]   dbg_starve_a;
    logic [7:0]   dbg_starve_b;
    logic         dbg_rr_ptr;

    // Arbiter view.
    modport slave (
        input  payload_a, id_a, qos_a, valid_a,
        output ready_a,
        input  payload_b, id_b, qos_b, valid_b,
        output ready_b,
        output payload_c, id_c, qos_c, valid_c,
        input  ready_c,
        input  conflict_c, release_c, releaseid_c,
        output out_cnt, err_release,
        output dbg_starve_a, dbg_starve_b, dbg_rr_ptr
    );

    // Environment view (upstream masters plus the enigma core).
    modport master (
        output payload_a, id_a, qos_a, valid_a,
        input  ready_a,
        output payload_b, id_b, qos_b, valid_b,
        input  ready_b,
        input  payload_c, id_c, qos_c, valid_c,
        output ready_c,
        output conflict_c, release_c, releaseid_c,
        input  out_cnt, err_release,
        input  dbg_starve_a, dbg_starve_b, dbg_rr_ptr
    );
endinterface

// File: rtl/enigma_qos_arb.sv
// Two-port QoS arbiter merging ports A and B into port C. A 64-entry
// scoreboard of in-flight IDs ({src, id}) blocks duplicate IDs. Winner
// order: starved port, then higher qos, then round-robin. The output
// stage is a single register.
module enigma_qos_arb #(
    parameter int STARVE_LIM = 15,
    parameter int MAX_OUT    = 64
) (
    input logic             clk,
    input logic             rst_n,
    enigma_qos_arb_if.slave bus
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);
    localparam logic [6:0] CAP = 7'(MAX_OUT);

    // Registered state.
    logic         valid_c_q,   valid_c_d;
    logic [127:0] payload_c_q, payload_c_d;
    logic [5:0]   id_c_q,      id_c_d;
    logic [1:0]   qos_c_q,     qos_c_d;
    logic [63:0]  sb_q,        sb_d;
    logic [6:0]   out_cnt_q,   out_cnt_d;
    logic         err_q,       err_d;
    logic         rr_q,        rr_d;
    logic [7:0]   starve_a_q,  starve_a_d;
    logic [7:0]   starve_b_q,  starve_b_d;

    // Arbitration signals.
    logic load_ok;
    logic elig_a, elig_b;
    logic sat_a, sat_b;
    logic win_b;
    logic gnt_a, gnt_b;
    logic rel_hit;

    // Starve counter update: cleared by a grant or an idle request,
    // bumped (saturating) on a lost arbitration, otherwise held.
    function automatic logic [7:0] starve_next(
        input logic [7:0] cur,
        input logic       gnt,
        input logic       vld,
        input logic       elig,
        input logic       ld_ok
    );
        logic [7:0] nxt;
        nxt = cur;
        if (gnt || !vld) begin
            nxt = 8'd0;
        end else if (elig && ld_ok && (cur < LIM)) begin
            nxt = cur + 8'd1;
        end
        return nxt;
    endfunction

    // Eligibility and winner selection against the pre-release scoreboard.
    always_comb begin
        load_ok = (!valid_c_q || bus.ready_c) && !bus.conflict_c;
        elig_a  = bus.valid_a && !sb_q[{1'b0, bus.id_a}] && (out_cnt_q < CAP);
        elig_b  = bus.valid_b && !sb_q[{1'b1, bus.id_b}] && (out_cnt_q < CAP);
        sat_a   = (starve_a_q == LIM);
        sat_b   = (starve_b_q == LIM);
        win_b   = 1'b0;
        if (elig_a && elig_b) begin
            if (sat_a && sat_b) begin
                win_b = rr_q;
            end else if (sat_a) begin
                win_b = 1'b0;
            end else if (sat_b) begin
                win_b = 1'b1;
            end else if (bus.qos_a != bus.qos_b) begin
                win_b = (bus.qos_b > bus.qos_a);
            end else begin
                win_b = rr_q;
            end
        end else begin
            // Only one contender (or none): it wins uncontested.
            win_b = elig_b;
        end
        gnt_a = load_ok && elig_a && !win_b;
        gnt_b = load_ok && elig_b && win_b;
    end

    // Next-state for output stage, scoreboard, counters and pointers.
    always_comb begin
        valid_c_d   = valid_c_q;
        payload_c_d = payload_c_q;
        id_c_d      = id_c_q;
        qos_c_d     = qos_c_q;
        sb_d        = sb_q;
        out_cnt_d   = out_cnt_q;
        err_d       = err_q;
        rr_d        = rr_q;
        rel_hit     = bus.release_c && sb_q[bus.releaseid_c];

        // Output register: load on grant, otherwise drain on accept.
        if (gnt_a) begin
            valid_c_d   = 1'b1;
            payload_c_d = bus.payload_a;
            id_c_d      = {1'b0, bus.id_a};
            qos_c_d     = bus.qos_a;
            rr_d        = 1'b1;
        end else if (gnt_b) begin
            valid_c_d   = 1'b1;
            payload_c_d = bus.payload_b;
            id_c_d      = {1'b1, bus.id_b};
            qos_c_d     = bus.qos_b;
            rr_d        = 1'b0;
        end else if (bus.ready_c) begin
            valid_c_d   = 1'b0;
        end

        // Release clears a live entry; releasing a dead one only flags.
        if (rel_hit) begin
            sb_d[bus.releaseid_c] = 1'b0;
        end else if (bus.release_c) begin
            err_d = 1'b1;
        end

        // A granted ID is never the released ID: it was not live.
        if (gnt_a) begin
            sb_d[{1'b0, bus.id_a}] = 1'b1;
        end
        if (gnt_b) begin
            sb_d[{1'b1, bus.id_b}] = 1'b1;
        end

        case ({gnt_a || gnt_b, rel_hit})
            2'b10:   out_cnt_d = out_cnt_q + 7'd1;
            2'b01:   out_cnt_d = out_cnt_q - 7'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        starve_a_d = starve_next(starve_a_q, gnt_a, bus.valid_a, elig_a, load_ok);
        starve_b_d = starve_next(starve_b_q, gnt_b, bus.valid_b, elig_b, load_ok);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_c_q   <= 1'b0;
            payload_c_q <= '0;
            id_c_q      <= '0;
            qos_c_q     <= '0;
            sb_q        <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            rr_q        <= 1'b0;
            starve_a_q  <= '0;
            starve_b_q  <= '0;
        end else begin
            valid_c_q   <= valid_c_d;
            payload_c_q <= payload_c_d;
            id_c_q      <= id_c_d;
            qos_c_q     <= qos_c_d;
            sb_q        <= sb_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            rr_q        <= rr_d;
            starve_a_q  <= starve_a_d;
            starve_b_q  <= starve_b_d;
        end
    end

    assign bus.ready_a      = gnt_a;
    assign bus.ready_b      = gnt_b;
    assign bus.valid_c      = valid_c_q;
    assign bus.payload_c    = payload_c_q;
    assign bus.id_c         = id_c_q;
    assign bus.qos_c        = qos_c_q;
    assign bus.out_cnt      = out_cnt_q;
    assign bus.err_release  = err_q;
    assign bus.dbg_starve_a = starve_a_q;
    assign bus.dbg_starve_b = starve_b_q;
    assign bus.dbg_rr_ptr   = rr_q;

endmodule

// File: tb/tb_enigma_qos_arb.sv
// Bench for enigma_qos_arb: directed scenarios with literal expectations,
// then randomized traffic, all tracked by a behavioural model that is
// compared against the DUT on every falling edge.
module tb_enigma_qos_arb;

    localparam int LIM = 15;
    localparam int CAP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    enigma_qos_arb_if bus ();

    enigma_qos_arb #(.STARVE_LIM(LIM), .MAX_OUT(CAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    bit           m_out[64];
    int           m_cnt;
    bit           m_err;
    int           m_st[2];
    int           m_rr;
    bit           m_vc;
    logic [127:0] m_pay;
    logic [5:0]   m_id;
    logic [1:0]   m_qos;
    bit           m_init = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT with model, then advance the model across the next edge.
    always @(negedge clk) begin : cmp
        bit ld, e0, e1, g0, g1;
        int sc0, sc1;
        ld  = (!m_vc || bus.ready_c) && !bus.conflict_c;
        e0  = bus.valid_a && !m_out[{1'b0, bus.id_a}] && (m_cnt < CAP);
        e1  = bus.valid_b && !m_out[{1'b1, bus.id_b}] && (m_cnt < CAP);
        // A saturated port outranks any qos; the round-robin favourite
        // gets a +1 tiebreak, so scores are never equal.
        sc0 = (m_st[0] == LIM) ? 1000 : 10 * int'(bus.qos_a);
        sc1 = (m_st[1] == LIM) ? 1000 : 10 * int'(bus.qos_b);
        if (m_rr == 0) sc0 += 1; else sc1 += 1;
        g0  = ld && e0 && (!e1 || sc0 > sc1);
        g1  = ld && e1 && (!e0 || sc1 > sc0);

        if (m_init) begin
            chk("ready_a", 128'(bus.ready_a), 128'(g0));
            chk("ready_b", 128'(bus.ready_b), 128'(g1));
            chk("valid_c", 128'(bus.valid_c), 128'(m_vc));
            if (m_vc) begin
                chk("payload_c", bus.payload_c, m_pay);
                chk("id_c", 128'(bus.id_c), 128'(m_id));
                chk("qos_c", 128'(bus.qos_c), 128'(m_qos));
            end
            chk("out_cnt", 128'(bus.out_cnt), 128'(m_cnt));
            chk("err_release", 128'(bus.err_release), 128'(m_err));
            chk("starve_a", 128'(bus.dbg_starve_a), 128'(m_st[0]));
            chk("starve_b", 128'(bus.dbg_starve_b), 128'(m_st[1]));
            chk("rr_ptr", 128'(bus.dbg_rr_ptr), 128'(m_rr));
        end

        if (!rst_n) begin
            foreach (m_out[i]) m_out[i] = 1'b0;
            m_cnt  = 0;
            m_err  = 1'b0;
            m_st[0] = 0;
            m_st[1] = 0;
            m_rr   = 0;
            m_vc   = 1'b0;
            m_pay  = '0;
            m_id   = '0;
            m_qos  = '0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (g0) begin
                m_vc = 1'b1; m_pay = bus.payload_a; m_id = {1'b0, bus.id_a}; m_qos = bus.qos_a;
            end else if (g1) begin
                m_vc = 1'b1; m_pay = bus.payload_b; m_id = {1'b1, bus.id_b}; m_qos = bus.qos_b;
            end else if (bus.ready_c) begin
                m_vc = 1'b0;
            end
            if (g0 || !bus.valid_a) m_st[0] = 0;
            else if (e0 && ld && m_st[0] < LIM) m_st[0]++;
            if (g1 || !bus.valid_b) m_st[1] = 0;
            else if (e1 && ld && m_st[1] < LIM) m_st[1]++;
            if (g0) m_rr = 1;
            if (g1) m_rr = 0;
            if (bus.release_c) begin
                if (m_out[bus.releaseid_c]) m_out[bus.releaseid_c] = 1'b0;
                else m_err = 1'b1;
            end
            if (g0) m_out[{1'b0, bus.id_a}] = 1'b1;
            if (g1) m_out[{1'b1, bus.id_b}] = 1'b1;
            m_cnt = 0;
            foreach (m_out[i]) m_cnt += int'(m_out[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_a     = 1'b0;
        bus.valid_b     = 1'b0;
        bus.id_a        = '0;
        bus.id_b        = '0;
        bus.qos_a       = '0;
        bus.qos_b       = '0;
        bus.payload_a   = '0;
        bus.payload_b   = '0;
        bus.ready_c     = 1'b1;
        bus.conflict_c  = 1'b0;
        bus.release_c   = 1'b0;
        bus.releaseid_c = '0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic [4:0] id, input logic [1:0] qos, input logic [127:0] pay);
        bus.valid_a = 1'b1; bus.id_a = id; bus.qos_a = qos; bus.payload_a = pay;
    endtask

    task automatic drive_b(input logic [4:0] id, input logic [1:0] qos, input logic [127:0] pay);
        bus.valid_b = 1'b1; bus.id_b = id; bus.qos_b = qos; bus.payload_b = pay;
    endtask

    task automatic rel(input logic [5:0] id);
        bus.release_c = 1'b1; bus.releaseid_c = id;
    endtask

    initial begin : main
        int losses;
        bit granted, have_prev, bump;
        logic [4:0] prev_b;
        logic [127:0] held;
        int outs[$];

        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst valid_c", 128'(bus.valid_c), 128'(0));
        chk("rst payload_c", bus.payload_c, 128'(0));
        chk("rst id_c", 128'(bus.id_c), 128'(0));
        chk("rst qos_c", 128'(bus.qos_c), 128'(0));
        chk("rst out_cnt", 128'(bus.out_cnt), 128'(0));
        chk("rst err", 128'(bus.err_release), 128'(0));
        chk("rst ready_a", 128'(bus.ready_a), 128'(0));
        chk("rst ready_b", 128'(bus.ready_b), 128'(0));

        // Basic merge.
        tick();
        drive_a(5'd3, 2'd1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        @(negedge clk);
        chk("merge ready_a", 128'(bus.ready_a), 128'(1));
        tick();
        bus.valid_a = 1'b0;
        @(negedge clk);
        chk("merge valid_c", 128'(bus.valid_c), 128'(1));
        chk("merge id_c", 128'(bus.id_c), 128'(6'h03));
        chk("merge out_cnt", 128'(bus.out_cnt), 128'(1));

        // QoS then round-robin.
        reset_dut();
        drive_a(5'd0, 2'd2, 128'hA0);
        drive_b(5'd0, 2'd1, 128'hB0);
        @(negedge clk);
        chk("qos ready_a", 128'(bus.ready_a), 128'(1));
        chk("qos ready_b", 128'(bus.ready_b), 128'(0));
        tick();
        drive_a(5'd1, 2'd1, 128'hA1);
        rel(6'h00);
        @(negedge clk);
        chk("rr1 id_c", 128'(bus.id_c), 128'(6'h00));
        chk("rr1 ready_b", 128'(bus.ready_b), 128'(1));
        tick();
        drive_b(5'd1, 2'd1, 128'hB1);
        rel(6'h20);
        @(negedge clk);
        chk("rr2 id_c", 128'(bus.id_c), 128'(6'h20));
        chk("rr2 ready_a", 128'(bus.ready_a), 128'(1));
        tick();
        idle();
        @(negedge clk);
        chk("rr3 id_c", 128'(bus.id_c), 128'(6'h01));

        // ID blocking and release.
        reset_dut();
        drive_a(5'd5, 2'd0, 128'h55);
        @(negedge clk);
        chk("blk first", 128'(bus.ready_a), 128'(1));
        tick();
        @(negedge clk);
        chk("blk dup", 128'(bus.ready_a), 128'(0));
        tick();
        rel(6'h05);
        @(negedge clk);
        chk("blk rel cycle", 128'(bus.ready_a), 128'(0));
        tick();
        bus.release_c = 1'b0;
        @(negedge clk);
        chk("blk after rel", 128'(bus.ready_a), 128'(1));

        // Starvation: B always wins on qos until A saturates.
        reset_dut();
        drive_a(5'd7, 2'd0, 128'hAA);
        drive_b(5'd0, 2'd3, 128'hBB);
        losses = 0; granted = 1'b0; have_prev = 1'b0; prev_b = '0;
        for (int c = 0; c < 40 && !granted; c++) begin
            bus.release_c   = have_prev;
            bus.releaseid_c = {1'b1, prev_b};
            have_prev = 1'b0;
            @(negedge clk);
            bump = bus.ready_b;
            if (bus.ready_a) granted = 1'b1;
            else losses++;
            if (bump) begin
                prev_b = bus.id_b;
                have_prev = 1'b1;
            end
            tick();
            if (bump) bus.id_b = bus.id_b + 5'd1;
        end
        chk("starve granted", 128'(granted), 128'(1));
        chk("starve losses", 128'(losses), 128'(15));
        bus.release_c = 1'b0;
        @(negedge clk);
        chk("starve cleared", 128'(bus.dbg_starve_a), 128'(0));

        // Backpressure then conflict.
        reset_dut();
        bus.ready_c = 1'b0;
        held = {$urandom, $urandom, $urandom, $urandom};
        drive_a(5'd1, 2'd2, held);
        @(negedge clk);
        chk("bp first grant", 128'(bus.ready_a), 128'(1));
        tick();
        drive_a(5'd2, 2'd1, 128'hA2);
        drive_b(5'd3, 2'd1, 128'hB3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp ready_a", 128'(bus.ready_a), 128'(0));
            chk("bp ready_b", 128'(bus.ready_b), 128'(0));
            chk("bp valid_c", 128'(bus.valid_c), 128'(1));
            chk("bp payload", bus.payload_c, held);
            tick();
        end
        bus.ready_c = 1'b1;
        bus.conflict_c = 1'b1;
        @(negedge clk);
        chk("cf ready_a", 128'(bus.ready_a), 128'(0));
        chk("cf ready_b", 128'(bus.ready_b), 128'(0));
        tick();
        @(negedge clk);
        chk("cf drained", 128'(bus.valid_c), 128'(0));
        chk("cf still blocked", 128'(bus.ready_b), 128'(0));
        tick();
        bus.conflict_c = 1'b0;
        @(negedge clk);
        chk("cf lifted ready_b", 128'(bus.ready_b), 128'(1));

        // Capacity of two.
        reset_dut();
        drive_a(5'd1, 2'd0, 128'hC1);
        @(negedge clk);
        chk("cap g1", 128'(bus.ready_a), 128'(1));
        tick();
        bus.valid_a = 1'b0;
        drive_b(5'd1, 2'd0, 128'hC2);
        @(negedge clk);
        chk("cap g2", 128'(bus.ready_b), 128'(1));
        tick();
        bus.valid_b = 1'b0;
        drive_a(5'd2, 2'd0, 128'hC3);
        @(negedge clk);
        chk("cap full", 128'(bus.ready_a), 128'(0));
        chk("cap out_cnt", 128'(bus.out_cnt), 128'(2));
        tick();
        rel(6'h01);
        @(negedge clk);
        chk("cap rel cycle", 128'(bus.ready_a), 128'(0));
        tick();
        bus.release_c = 1'b0;
        @(negedge clk);
        chk("cap after rel", 128'(bus.ready_a), 128'(1));
        chk("cap out_cnt 1", 128'(bus.out_cnt), 128'(1));

        // Invalid release, then reset mid-stream.
        reset_dut();
        rel(6'h21);
        tick();
        bus.release_c = 1'b0;
        bus.ready_c = 1'b0;
        drive_a(5'd4, 2'd1, 128'hD4);
        @(negedge clk);
        chk("err set", 128'(bus.err_release), 128'(1));
        tick();
        bus.valid_a = 1'b0;
        @(negedge clk);
        chk("pre-rst valid_c", 128'(bus.valid_c), 128'(1));
        chk("pre-rst out_cnt", 128'(bus.out_cnt), 128'(1));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst valid_c", 128'(bus.valid_c), 128'(0));
        chk("midrst out_cnt", 128'(bus.out_cnt), 128'(0));
        chk("midrst err", 128'(bus.err_release), 128'(0));

        // Randomized traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n          = ($urandom_range(0, 499) != 0);
            bus.valid_a    = ($urandom_range(0, 3) != 0);
            bus.valid_b    = ($urandom_range(0, 3) != 0);
            bus.id_a       = 5'($urandom_range(0, 7));
            bus.id_b       = 5'($urandom_range(0, 7));
            bus.qos_a      = 2'($urandom_range(0, 3));
            bus.qos_b      = 2'($urandom_range(0, 3));
            bus.payload_a  = {$urandom, $urandom, $urandom, $urandom};
            bus.payload_b  = {$urandom, $urandom, $urandom, $urandom};
            bus.ready_c    = ($urandom_range(0, 3) != 0);
            bus.conflict_c = ($urandom_range(0, 7) == 0);
            outs.delete();
            foreach (m_out[i]) if (m_out[i]) outs.push_back(i);
            bus.release_c = 1'b0;
            if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                rel(6'(outs[$urandom_range(0, outs.size() - 1)]));
            end else if ($urandom_range(0, 63) == 0) begin
                rel(6'($urandom_range(0, 63)));
            end
        end
        rst_n = 1'b1;
        idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enigma_qos_arb.md
# enigma_qos_arb

- Two-port QoS arbiter that merges request ports A and B into the single downstream port C of the enigma datapath.
- Tracks outstanding transaction IDs in a 64-entry scoreboard and blocks any request whose ID is already in flight.
- Resolves contention by QoS first, then round-robin, with an aging override that guarantees forward progress.
- Sits between the two upstream masters and the enigma core. The core returns `conflict_c` and `release_c`/`releaseid_c` to this block.

## Interface

Parameters:
- `STARVE_LIM`, default 15: consecutive lost arbitrations after which a port is force-granted. Range 1..255.
- `MAX_OUT`, default 64: maximum outstanding IDs. Range 1..64.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `payload_a` in 128, `id_a` in 5, `qos_a` in 2, `valid_a` in 1: port A request.
- `ready_a` out 1: port A accept.
- `payload_b` in 128, `id_b` in 5, `qos_b` in 2, `valid_b` in 1: port B request.
- `ready_b` out 1: port B accept.
- `payload_c` out 128, `id_c` out 6, `qos_c` out 2, `valid_c` out 1: merged output. `id_c = {src, id}`, where src is 0 for A and 1 for B.
- `ready_c` in 1: downstream accept.
- `conflict_c` in 1: downstream stall. While high, no new grant is made.
- `release_c` in 1, `releaseid_c` in 6: retire the outstanding 6-bit ID.
- `out_cnt` out 7: number of outstanding IDs.
- `err_release` out 1: sticky flag, set on release of an ID that is not outstanding.

## Operation

- Output stage is a single register (`valid_c`, `payload_c`, `id_c`, `qos_c`).
  - `load_ok = (!valid_c | ready_c) & !conflict_c`.
  - Port C data is held stable while `valid_c & !ready_c`.
- Eligibility:
  - Port A is eligible when `valid_a & !sb[{0,id_a}] & (out_cnt < MAX_OUT)`.
  - Port B is eligible when `valid_b & !sb[{1,id_b}] & (out_cnt < MAX_OUT)`.
  - `sb` is the registered 64-bit scoreboard.
- Winner selection, applied in priority order:
  1. A port whose starve counter equals `STARVE_LIM` wins. If both are saturated, `rr_ptr` decides.
  2. Otherwise the higher qos wins.
  3. On equal qos, `rr_ptr` decides (0 = A preferred).
- Grant and ready:
  - `ready_x = load_ok & eligible_x & winner==x`. This is combinational, and at most one of `ready_a`/`ready_b` is high.
  - Ready never asserts for an ineligible port.
- On a grant (`ready_x & valid_x`):
  - Load the output register from port x.
  - Set `sb[{x,id_x}]`.
  - Set `rr_ptr` to the other port.
  - Clear `starve_x`.
- Starve counters:
  - `starve_x` increments, saturating at `STARVE_LIM`, in any cycle where port x is eligible, `load_ok` is high and x is not granted.
  - It clears when `valid_x` is low.
  - It holds otherwise, including while `conflict_c` or backpressure is active.
- Release handling:
  - `release_c` clears `sb[releaseid_c]`.
  - If that bit was already 0, no table change occurs and `err_release` is set until reset.
- `out_cnt` tracks `popcount(sb)`:
  - +1 on a grant.
  - −1 on a valid release.
  - Unchanged when both happen in the same cycle.
- Same-cycle grant and release of the same ID cannot occur, because eligibility uses the pre-release `sb`.

## Timing

- Reset values:
  - `valid_c`=0, `payload_c`=0, `id_c`=0, `qos_c`=0.
  - `ready_a`=`ready_b`=0 (output stage empty, scoreboard empty; ready then follows valid combinationally).
  - `sb`=0, `out_cnt`=0, `err_release`=0.
  - `rr_ptr`=0, starve counters 0.
- Reset mid-operation discards the held output beat and all outstanding state. No release is required afterwards.
- Latency: a grant in cycle N gives `valid_c` high in cycle N+1.
- Throughput: 1 beat/cycle when `ready_c`=1 and `conflict_c`=0.
- A released ID is eligible in the cycle after `release_c` is sampled.
- A `conflict_c` asserted in cycle N blocks any grant in cycle N. The held beat stays valid and may still complete if `ready_c`=1.
- `err_release` rises the cycle after an invalid release.

## Test plan

- **Basic merge.** A sends id 3 qos 1 with `ready_c`=1. Expect `ready_a`=1, then next cycle `valid_c`=1, `id_c`=0x03, `out_cnt`=1.
- **QoS and round-robin.**
  - A qos 2 and B qos 1 both valid: A wins.
  - Then A qos 1 and B qos 1: B wins (`rr_ptr`).
  - Then A wins again. `id_c` sequence is 0x0x, 0x2x, 0x0x.
- **ID blocking.**
  - A id 5 is granted with no release; A id 5 again keeps `ready_a`=0.
  - Release `releaseid_c`=0x05; `ready_a`=1 the following cycle.
- **Starvation.**
  - B holds qos 3 continuously with fresh IDs; A holds qos 0. Release every issued B ID one cycle after it is issued so B stays eligible.
  - A is granted after exactly 15 losses. `starve_a` then returns to 0.
- **Backpressure, conflict and capacity.**
  - With `ready_c`=0, the output beat is held stable for 4 cycles and `ready_a`/`ready_b`=0.
  - With `conflict_c`=1, no grant occurs.
  - With `MAX_OUT`=2, a third grant is blocked until a release.
- **Errors and reset.**
  - Releasing ID 0x21 while not outstanding sets `err_release`=1.
  - Asserting reset mid-stream clears `valid_c`, `out_cnt` and `err_release` next cycle.
